// File: rtl/adc_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_sequencer_pkg
// Description : Shared state encoding and default timing constants for the
//               ADC scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_scan_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_START   = 3'd2,
        ST_CONVERT = 3'd3,
        ST_STORE   = 3'd4
    } state_t;

    localparam int DEF_BITS           = 6;
    localparam int DEF_CHANNELS       = 4;
    localparam int DEF_SETTLE_CYCLES  = 3;
    localparam int DEF_TIMEOUT_CYCLES = 20;

endpackage
`default_nettype wire

// File: rtl/adc_chan_pick.sv
`default_nettype none
// ============================================================================
// Module      : adc_chan_pick
// Description : Priority encoder returning the lowest set mask bit above the
//               current index (or from bit 0 when i_first is set).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_chan_pick #(
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = 2
) (
    input  logic [CHANNELS-1:0] i_mask,
    input  logic [CHAN_W-1:0]   i_cur,
    input  logic                i_first,
    output logic [CHAN_W-1:0]   o_next,
    output logic                o_any
);

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        o_next = '0;
        o_any  = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_first || (CHAN_W'(i) > i_cur))) begin
                o_next = CHAN_W'(i);
                o_any  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_sequencer
// Description : Multi-channel scan controller: selects mux channel, settles,
//               starts the SAR ADC, captures results and streams them tagged.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer
    import adc_scan_sequencer_pkg::*;
#(
    parameter int BITS           = DEF_BITS,
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CHAN_W         = $clog2(CHANNELS)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Trigger,
    input  logic                Enable,
    input  logic [CHANNELS-1:0] ChanMask,
    input  logic                ErrClear,
    output logic                AdcStart,
    input  logic                AdcDone,
    input  logic [BITS-1:0]     AdcResult,
    output logic [CHAN_W-1:0]   MuxSel,
    output logic                MuxEn,
    output logic                Busy,
    output logic                ResultValid,
    output logic [CHAN_W-1:0]   ResultChan,
    output logic [BITS-1:0]     ResultData,
    output logic                ScanDone,
    output logic                Timeout
);

    localparam int C_CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    state_t                state_q, state_d;
    logic [CHANNELS-1:0]   mask_q, mask_d;
    logic [C_CNT_W-1:0]    cnt_q, cnt_d;
    logic                  done_prev_q;
    logic                  adc_start_q, adc_start_d;
    logic [CHAN_W-1:0]     mux_sel_q, mux_sel_d;
    logic                  mux_en_q, mux_en_d;
    logic                  busy_q, busy_d;
    logic                  result_valid_q, result_valid_d;
    logic [CHAN_W-1:0]     result_chan_q, result_chan_d;
    logic [BITS-1:0]       result_data_q, result_data_d;
    logic                  scan_done_q, scan_done_d;
    logic                  timeout_q, timeout_d;

    logic [CHANNELS-1:0]   w_mask_clr;
    logic [CHANNELS-1:0]   w_pick_mask;
    logic                  w_pick_first;
    logic [CHAN_W-1:0]     w_pick_idx;
    logic                  w_pick_any;
    logic                  w_done_rise;

    // One encoder serves both the first pick (from IDLE) and the advance (from STORE).
    assign w_mask_clr   = mask_q & ~(CHANNELS'(1) << mux_sel_q);
    assign w_pick_first = (state_q == ST_IDLE);
    assign w_pick_mask  = w_pick_first ? ChanMask : w_mask_clr;
    assign w_done_rise  = AdcDone & ~done_prev_q;

    adc_chan_pick #(
        .CHANNELS (CHANNELS),
        .CHAN_W   (CHAN_W)
    ) u_chan_pick (
        .i_mask  (w_pick_mask),
        .i_cur   (mux_sel_q),
        .i_first (w_pick_first),
        .o_next  (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        cnt_d          = cnt_q;
        adc_start_d    = 1'b0;
        mux_sel_d      = mux_sel_q;
        mux_en_d       = mux_en_q;
        result_valid_d = 1'b0;
        result_chan_d  = result_chan_q;
        result_data_d  = result_data_q;
        scan_done_d    = 1'b0;
        timeout_d      = timeout_q & ~ErrClear;

        case (state_q)
            ST_IDLE: begin
                if ((Trigger || Enable) && w_pick_any) begin
                    mask_d    = ChanMask;
                    mux_sel_d = w_pick_idx;
                    mux_en_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == C_CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            ST_START: begin
                adc_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (w_done_rise) begin
                    result_valid_d = 1'b1;
                    result_chan_d  = mux_sel_q;
                    result_data_d  = AdcResult;
                    state_d        = ST_STORE;
                end else if (cnt_q == C_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Skipped channel: no result, but advance exactly as a normal store.
                    timeout_d = 1'b1;
                    state_d   = ST_STORE;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            ST_STORE: begin
                mask_d = w_mask_clr;
                if (w_pick_any) begin
                    mux_sel_d = w_pick_idx;
                    cnt_d     = '0;
                    state_d   = ST_SETTLE;
                end else begin
                    scan_done_d = 1'b1;
                    mux_en_d    = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            mask_q         <= '0;
            cnt_q          <= '0;
            done_prev_q    <= 1'b0;
            adc_start_q    <= 1'b0;
            mux_sel_q      <= '0;
            mux_en_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_chan_q  <= '0;
            result_data_q  <= '0;
            scan_done_q    <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            cnt_q          <= cnt_d;
            done_prev_q    <= AdcDone;
            adc_start_q    <= adc_start_d;
            mux_sel_q      <= mux_sel_d;
            mux_en_q       <= mux_en_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_chan_q  <= result_chan_d;
            result_data_q  <= result_data_d;
            scan_done_q    <= scan_done_d;
            timeout_q      <= timeout_d;
        end
    end

    assign AdcStart    = adc_start_q;
    assign MuxSel      = mux_sel_q;
    assign MuxEn       = mux_en_q;
    assign Busy        = busy_q;
    assign ResultValid = result_valid_q;
    assign ResultChan  = result_chan_q;
    assign ResultData  = result_data_q;
    assign ScanDone    = scan_done_q;
    assign Timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_sequencer
// Description : Directed, table-driven bench for adc_scan_sequencer with a
//               behavioural SAR ADC / analog mux model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Trigger = 1'b0;
    logic       Enable = 1'b0;
    logic [3:0] ChanMask = 4'b0000;
    logic       ErrClear = 1'b0;
    logic       AdcStart;
    logic       AdcDone;
    logic [5:0] AdcResult;
    logic [1:0] MuxSel;
    logic       MuxEn;
    logic       Busy;
    logic       ResultValid;
    logic [1:0] ResultChan;
    logic [5:0] ResultData;
    logic       ScanDone;
    logic       Timeout;

    adc_scan_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Trigger     (Trigger),
        .Enable      (Enable),
        .ChanMask    (ChanMask),
        .ErrClear    (ErrClear),
        .AdcStart    (AdcStart),
        .AdcDone     (AdcDone),
        .AdcResult   (AdcResult),
        .MuxSel      (MuxSel),
        .MuxEn       (MuxEn),
        .Busy        (Busy),
        .ResultValid (ResultValid),
        .ResultChan  (ResultChan),
        .ResultData  (ResultData),
        .ScanDone    (ScanDone),
        .Timeout     (Timeout)
    );

    always #5 Clk = ~Clk;

    // Analog mux + ADC model: Done rises 8 clocks after Start, dead channels never finish.
    logic [5:0] chan_val [4];
    logic [3:0] dead = 4'b0000;
    logic [3:0] adc_cnt;
    logic       adc_busy;
    logic [1:0] adc_ch;

    initial begin
        chan_val[0] = 6'h0C;
        chan_val[1] = 6'h15;
        chan_val[2] = 6'h33;
        chan_val[3] = 6'h2A;
    end

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            AdcDone   <= 1'b0;
            AdcResult <= 6'h00;
            adc_busy  <= 1'b0;
            adc_cnt   <= 4'd0;
            adc_ch    <= 2'd0;
        end else if (AdcStart) begin
            AdcDone  <= 1'b0;
            adc_busy <= 1'b1;
            adc_cnt  <= 4'd0;
            adc_ch   <= MuxSel;
        end else if (adc_busy) begin
            if (adc_cnt == 4'd7) begin
                adc_busy <= 1'b0;
                if (!dead[adc_ch]) begin
                    AdcDone   <= 1'b1;
                    AdcResult <= chan_val[adc_ch];
                end
            end else begin
                adc_cnt <= adc_cnt + 4'd1;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [1:0] res_ch[$];
    logic [5:0] res_dat[$];
    int  scans = 0, max_w = 0, st_w = 0, gap = -1, sel_bad = 0, cyc = 0, t_muxen = 0;
    bit  busy_seen = 0, first_pending = 0, muxen_prev = 0, start_prev = 0;

    always @(negedge Clk) begin
        cyc++;
        if (ResultValid) begin
            res_ch.push_back(ResultChan);
            res_dat.push_back(ResultData);
            if (MuxSel != ResultChan) sel_bad++;
        end
        if (ScanDone) scans++;
        if (Busy) busy_seen = 1;
        if (AdcStart) begin
            st_w++;
            if (st_w > max_w) max_w = st_w;
        end else begin
            st_w = 0;
        end
        if (MuxEn && !muxen_prev) begin
            t_muxen       = cyc;
            first_pending = 1;
        end
        if (AdcStart && !start_prev && first_pending) begin
            gap           = cyc - t_muxen;
            first_pending = 0;
        end
        muxen_prev = MuxEn;
        start_prev = AdcStart;
    end

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        res_ch.delete();
        res_dat.delete();
        scans = 0; max_w = 0; gap = -1; sel_bad = 0;
        busy_seen = 0; first_pending = 0;
    endtask

    task automatic pulse_trigger(input logic [3:0] m);
        @(negedge Clk);
        ChanMask = m;
        Trigger  = 1'b1;
        @(negedge Clk);
        Trigger  = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        repeat (2) @(negedge Clk);
        while (Busy && n < bound) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_idle", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge Clk);
    endtask

    typedef struct packed {
        logic [3:0]  mask;
        logic [3:0]  dead;
        logic [2:0]  n_res;
        logic [7:0]  ch_pk;    // {r3,r2,r1,r0}
        logic [23:0] dat_pk;   // {r3,r2,r1,r0}
        logic        exp_to;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int k);
        vec_t v;
        v    = vecs[k];
        dead = v.dead;
        @(negedge Clk);
        ErrClear = 1'b1;
        @(negedge Clk);
        ErrClear = 1'b0;
        chk($sformatf("v%0d_timeout_cleared", k), {31'd0, Timeout}, 32'd0);
        clear_mon();
        pulse_trigger(v.mask);
        wait_idle(300);
        chk($sformatf("v%0d_busy_seen", k), {31'd0, busy_seen}, {31'd0, (v.mask != 4'b0)});
        chk($sformatf("v%0d_n_results", k), res_ch.size(), {29'd0, v.n_res});
        for (int j = 0; j < int'(v.n_res); j++) begin
            if (j < res_ch.size()) begin
                chk($sformatf("v%0d_res%0d_chan", k, j), {30'd0, res_ch[j]}, {30'd0, v.ch_pk[j*2 +: 2]});
                chk($sformatf("v%0d_res%0d_data", k, j), {26'd0, res_dat[j]}, {26'd0, v.dat_pk[j*6 +: 6]});
            end
        end
        chk($sformatf("v%0d_scan_done", k), scans, {31'd0, (v.mask != 4'b0)});
        chk($sformatf("v%0d_timeout", k), {31'd0, Timeout}, {31'd0, v.exp_to});
        if (v.mask != 4'b0) begin
            chk($sformatf("v%0d_start_gap", k), gap, 32'd4);
            chk($sformatf("v%0d_start_width", k), max_w, 32'd1);
            chk($sformatf("v%0d_muxsel_stable", k), sel_bad, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{mask: 4'b1010, dead: 4'b0000, n_res: 3'd2,
                    ch_pk: {2'd0, 2'd0, 2'd3, 2'd1}, dat_pk: {6'h00, 6'h00, 6'h2A, 6'h15}, exp_to: 1'b0};
        vecs[1] = '{mask: 4'b0111, dead: 4'b0100, n_res: 3'd2,
                    ch_pk: {2'd0, 2'd0, 2'd1, 2'd0}, dat_pk: {6'h00, 6'h00, 6'h15, 6'h0C}, exp_to: 1'b1};
        vecs[2] = '{mask: 4'b1111, dead: 4'b0000, n_res: 3'd4,
                    ch_pk: {2'd3, 2'd2, 2'd1, 2'd0}, dat_pk: {6'h2A, 6'h33, 6'h15, 6'h0C}, exp_to: 1'b0};
        vecs[3] = '{mask: 4'b0001, dead: 4'b0001, n_res: 3'd0,
                    ch_pk: 8'd0, dat_pk: 24'd0, exp_to: 1'b1};
        vecs[4] = '{mask: 4'b1000, dead: 4'b0000, n_res: 3'd1,
                    ch_pk: {2'd0, 2'd0, 2'd0, 2'd3}, dat_pk: {6'h00, 6'h00, 6'h00, 6'h2A}, exp_to: 1'b0};
        vecs[5] = '{mask: 4'b0000, dead: 4'b0000, n_res: 3'd0,
                    ch_pk: 8'd0, dat_pk: 24'd0, exp_to: 1'b0};

        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset_outputs", {15'd0, AdcStart, MuxSel, MuxEn, Busy, ResultValid, ResultChan,
                              ResultData, ScanDone, Timeout}, 32'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Trigger while busy and mask change mid-scan have no effect
        dead = 4'b0000;
        clear_mon();
        pulse_trigger(4'b0001);
        repeat (4) @(negedge Clk);
        ChanMask = 4'b1111;
        Trigger  = 1'b1;
        @(negedge Clk);
        Trigger  = 1'b0;
        wait_idle(300);
        repeat (20) @(negedge Clk);
        chk("busy_trig_scans", scans, 32'd1);
        chk("busy_trig_results", res_ch.size(), 32'd1);
        if (res_ch.size() > 0) chk("busy_trig_chan", {30'd0, res_ch[0]}, 32'd0);
        chk("busy_trig_idle", {31'd0, Busy}, 32'd0);

        // Continuous scanning with Enable, then drop Enable mid-scan
        clear_mon();
        @(negedge Clk);
        ChanMask = 4'b0001;
        Enable   = 1'b1;
        begin
            int n = 0;
            while (scans < 3 && n < 300) begin
                @(negedge Clk);
                n++;
            end
            chk("enable_three_scans", {31'd0, (scans >= 3)}, 32'd1);
            n = 0;
            while (!Busy && n < 10) begin
                @(negedge Clk);
                n++;
            end
            chk("enable_rescan_busy", {31'd0, Busy}, 32'd1);
        end
        Enable = 1'b0;
        wait_idle(300);
        repeat (20) @(negedge Clk);
        chk("enable_total_scans", scans, 32'd4);
        chk("enable_total_results", res_ch.size(), 32'd4);
        if (res_dat.size() >= 4) chk("enable_last_data", {26'd0, res_dat[3]}, 32'h0C);
        chk("enable_idle", {31'd0, Busy}, 32'd0);

        // Reset during CONVERT
        clear_mon();
        pulse_trigger(4'b1010);
        begin
            int n = 0;
            while (!AdcStart && n < 30) begin
                @(negedge Clk);
                n++;
            end
            chk("rst_mid_saw_start", {31'd0, AdcStart}, 32'd1);
        end
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {15'd0, AdcStart, MuxSel, MuxEn, Busy, ResultValid, ResultChan,
                                ResultData, ScanDone, Timeout}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
